// File: rtl/mem_port_master.sv
// mem_port_master: single-outstanding request/response master for a 32-bit
// combined memory with combinational read and edge-sampled write strobe.
module mem_port_master #(
  parameter int MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] addr,
  output logic [31:0] writeData,
  output logic        writeEnable,
  input  logic [31:0] read,
  output logic [7:0]  err_count
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;
  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        legal;
  assign legal = (req_addr[1:0] == 2'b00) && (req_addr < 32'(MEM_BYTES));
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d  = req_addr;
        wdata_d = req_wdata;
        rdata_d = '0;
        err_d   = !legal;
        state_d = !legal ? RESP : (req_write ? WR : RD);
      end
      RD: begin
        rdata_d = read;
        state_d = RESP;
      end
      WR: state_d = RESP;
      default: if (resp_ready) begin
        state_d = IDLE;
        cnt_d   = (err_q && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  // Strobe decoded straight from state so an async reset drops it at once.
  assign writeEnable = (state_q == WR);
  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = (state_q == RESP);
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;
  assign addr        = addr_q;
  assign writeData   = wdata_q;
  assign err_count   = cnt_q;
endmodule

// File: tb/tb_mem_port_master.sv
// tb_mem_port_master: scoreboard bench with a behavioural memory and a
// reference memory image predicting load data, errors and latency.
module tb_mem_port_master;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] addr;
  logic [31:0] writeData;
  logic        writeEnable;
  logic [31:0] read;
  logic [7:0]  err_count;

  mem_port_master #(.MEM_BYTES(256)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .addr(addr), .writeData(writeData),
    .writeEnable(writeEnable), .read(read), .err_count(err_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  assign read = mem[addr[7:2]];
  always @(posedge clk) if (writeEnable) mem[addr[7:2]] <= writeData;

  int we_cnt = 0;
  logic [31:0] we_addr = '0, we_data = '0;
  always @(negedge clk) if (writeEnable) begin
    we_cnt  = we_cnt + 1;
    we_addr = addr;
    we_data = writeData;
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] lat;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
  } sb_t;
  sb_t sbq[$];

  int checks = 0, fails = 0, exp_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input int hold);
    sb_t e;
    logic lg;
    int k, we0;
    logic [31:0] held;
    lg = (a[1:0] == 2'b00) && (a < 32'd256);
    e.err = !lg;
    e.rdata = (lg && !w) ? ref_mem[a[7:2]] : 32'd0;
    e.lat = lg ? 32'd2 : 32'd1;
    e.we = lg && w;
    e.waddr = a;
    e.wdata = d;
    if (lg && w) ref_mem[a[7:2]] = d;
    if (!lg && exp_cnt < 255) exp_cnt++;
    sbq.push_back(e);
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    we0 = we_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = ~w; req_addr = $urandom; req_wdata = $urandom;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!resp_valid && k < 8);
    e = sbq.pop_front();
    chk("latency", 32'(k), e.lat);
    chk("rdata", resp_rdata, e.rdata);
    chk("err", {31'd0, resp_err}, {31'd0, e.err});
    chk("we_pulses", 32'(we_cnt - we0), {31'd0, e.we});
    if (e.we) begin
      chk("we_addr", we_addr, e.waddr);
      chk("we_data", we_data, e.wdata);
    end
    held = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, held);
      chk("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk("idle_after", {31'd0, req_ready}, 32'd1);
    chk("valid_after", {31'd0, resp_valid}, 32'd0);
    chk("err_count", {24'd0, err_count}, 32'(exp_cnt));
  endtask

  task automatic chk_reset_vals();
    chk("rst_we", {31'd0, writeEnable}, 32'd0);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_wdata", writeData, 32'd0);
    chk("rst_cnt", {24'd0, err_count}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int we0;
    logic [31:0] a;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'(i * 3 + 1);
      ref_mem[i] = 32'(i * 3 + 1);
    end
    mem[32] = 32'd12; ref_mem[32] = 32'd12;
    mem[33] = 32'd10; ref_mem[33] = 32'd10;
    #1;
    chk_reset_vals();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    xact(1'b0, 32'h80, 32'd0, 0);
    xact(1'b1, 32'h90, 32'd15, 0);
    xact(1'b0, 32'h90, 32'd0, 0);
    xact(1'b0, 32'h81, 32'd0, 0);
    xact(1'b1, 32'h100, 32'd99, 0);
    xact(1'b0, 32'hFC, 32'd0, 0);
    xact(1'b0, 32'h84, 32'd0, 3);
    // Reset in the middle of a store: the write must vanish without a response.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'hA0; req_wdata = 32'd77;
    we0 = we_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("mid_wr_we", {31'd0, writeEnable}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals();
    @(negedge clk);
    reset_n = 1'b1;
    exp_cnt = 0;
    chk("mid_wr_no_write", mem[40], ref_mem[40]);
    xact(1'b0, 32'h80, 32'd0, 0);
    xact(1'b0, 32'hA0, 32'd0, 0);
    for (int i = 0; i < 24; i++) begin
      a = 32'($urandom_range(0, 32'h110));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      xact(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 2)));
    end
    for (int i = 0; i < 256; i++) begin
      a = {24'd0, 8'(i)};
      if (a[1:0] == 2'b00) a[0] = 1'b1;
      xact(1'(i & 1), a, 32'd0, 0);
    end
    chk("err_count_sat", {24'd0, err_count}, 32'd255);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
